// File: rtl/freq_counter_if.sv
// freq_counter_if: measurement bus between the frequency counter front end,
// the signal source and the LCD controller.
//
// Signals:
//   sig_in      signal under measurement (asynchronous to clk)
//   gate_count  32-bit window position, wraps GATE_CYCLES -> 1
//   data0..7    latched BCD result, data0 = least significant digit
//   overflow    latched with the data, 1 = window count saturated
//   done        result strobe
//
// Strobe semantics: done is a one-cycle valid with no ready. data*/overflow
// are valid in the cycle done is high and hold until the next done; the
// consumer must sample in that cycle because there is no back-pressure.
//
// Modports:
//   master  source / consumer side (drives sig_in, reads results)
//   slave   freq_counter side
interface freq_counter_if;
   logic        sig_in;
   logic [31:0] gate_count;
   logic [3:0]  data0;
   logic [3:0]  data1;
   logic [3:0]  data2;
   logic [3:0]  data3;
   logic [3:0]  data4;
   logic [3:0]  data5;
   logic [3:0]  data6;
   logic [3:0]  data7;
   logic        overflow;
   logic        done;

   modport master (
      output sig_in,
      input  gate_count, data0, data1, data2, data3,
             data4, data5, data6, data7, overflow, done
   );

   modport slave (
      input  sig_in,
      output gate_count, data0, data1, data2, data3,
             data4, data5, data6, data7, overflow, done
   );
endinterface

// File: rtl/freq_counter.sv
// freq_counter: measurement front end of the LCD frequency counter.
// Synchronises sig_in, counts its rising edges in BCD over a window of
// GATE_CYCLES clocks and latches the result at each window boundary.
//
// Parameters:
//   GATE_CYCLES  window length in clk cycles (2 .. 2^32-1)
//   DIGITS       active BCD digits (1..8); higher digits read as 0
//
// Ports:
//   clk  system clock, all logic on its rising edge
//   rst  synchronous reset, active-high
//   bus  freq_counter_if slave modport (sig_in in; gate_count, data0..7,
//        overflow, done out)
module freq_counter #(
   parameter int unsigned GATE_CYCLES = 50000000,
   parameter int unsigned DIGITS      = 8
) (
   input  logic          clk,
   input  logic          rst,
   freq_counter_if.slave bus
);

   localparam logic [31:0] GATE_END  = 32'(GATE_CYCLES);
   localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);

   logic                   s1, s2, s3;
   logic                   edge_hit;
   logic [31:0]            gate_count;
   logic                   boundary;
   logic [DIGITS-1:0][3:0] acc;
   logic [DIGITS-1:0][3:0] acc_inc;
   logic [DIGITS-1:0][3:0] acc_next;
   logic                   all_nines;
   logic                   carry;
   logic                   sat;
   logic                   sat_hit;
   logic [7:0][3:0]        data_q;
   logic                   overflow_q;

   // s1/s2 resolve metastability, s3 holds the previous sample for edge detect
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= bus.sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign edge_hit = s2 & ~s3;

   // Starts at 0 after reset but wraps to 1, so the first window
   // (0..GATE_CYCLES-1) and every later one (GATE_CYCLES,1..GATE_CYCLES-1)
   // both last exactly GATE_CYCLES cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         gate_count <= 32'd0;
      end else if (gate_count == GATE_END) begin
         gate_count <= 32'd1;
      end else begin
         gate_count <= gate_count + 32'd1;
      end
   end

   assign boundary = (gate_count == GATE_LAST);

   // Decimal ripple increment; at all-nines an edge is absorbed and flagged
   always_comb begin
      all_nines = 1'b1;
      carry     = edge_hit;
      acc_inc   = acc;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (acc[i] != 4'd9) begin
            all_nines = 1'b0;
         end
         if (carry) begin
            if (acc[i] == 4'd9) begin
               acc_inc[i] = 4'd0;
            end else begin
               acc_inc[i] = acc[i] + 4'd1;
               carry      = 1'b0;
            end
         end
      end
      sat_hit  = edge_hit & all_nines;
      acc_next = sat_hit ? acc : acc_inc;
   end

   // The boundary cycle's own edge (and its saturation) goes into the
   // reported result, then the accumulator restarts from zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         sat        <= 1'b0;
         data_q     <= '0;
         overflow_q <= 1'b0;
      end else if (boundary) begin
         acc        <= '0;
         sat        <= 1'b0;
         data_q     <= 32'(acc_next);
         overflow_q <= sat | sat_hit;
      end else begin
         acc        <= acc_next;
         sat        <= sat | sat_hit;
      end
   end

   assign bus.gate_count = gate_count;
   assign bus.done       = (gate_count == GATE_END);
   assign bus.overflow   = overflow_q;
   assign bus.data0      = data_q[0];
   assign bus.data1      = data_q[1];
   assign bus.data2      = data_q[2];
   assign bus.data3      = data_q[3];
   assign bus.data4      = data_q[4];
   assign bus.data5      = data_q[5];
   assign bus.data6      = data_q[6];
   assign bus.data7      = data_q[7];

endmodule

// File: tb/tb_freq_counter.sv
// tb_freq_counter: directed bench for freq_counter. Three instances cover
// the different window lengths / digit counts:
//   dut_a  GATE_CYCLES=100,  DIGITS=8  reset, steady count, boundary edge
//   dut_b  GATE_CYCLES=2000, DIGITS=8  BCD carry, mid-window reset
//   dut_c  GATE_CYCLES=300,  DIGITS=2  saturation
module tb_freq_counter;

   logic clk;
   logic rst;

   freq_counter_if ifa ();
   freq_counter_if ifb ();
   freq_counter_if ifc ();

   freq_counter #(.GATE_CYCLES(100), .DIGITS(8)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   freq_counter #(.GATE_CYCLES(2000), .DIGITS(8)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   freq_counter #(.GATE_CYCLES(300), .DIGITS(2)) dut_c (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Packed view of all eight digits, data7 in the top nibble
   logic [31:0] dig_a, dig_b, dig_c;
   assign dig_a = {ifa.data7, ifa.data6, ifa.data5, ifa.data4,
                   ifa.data3, ifa.data2, ifa.data1, ifa.data0};
   assign dig_b = {ifb.data7, ifb.data6, ifb.data5, ifb.data4,
                   ifb.data3, ifb.data2, ifb.data1, ifb.data0};
   assign dig_c = {ifc.data7, ifc.data6, ifc.data5, ifc.data4,
                   ifc.data3, ifc.data2, ifc.data1, ifc.data0};

   int n_checks = 0;
   int n_pass   = 0;

   // auto-toggle half periods (0 = hold) and their phase counters
   int half_a = 0, half_b = 0, half_c = 0;
   int cnt_a  = 0, cnt_b  = 0, cnt_c  = 0;

   // ---------------- model helpers ----------------
   function automatic logic [31:0] to_bcd(input int n);
      logic [31:0] r;
      int          v;
      r = '0;
      v = n;
      for (int i = 0; i < 8; i++) begin
         r[i*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic bit is_bcd(input logic [31:0] d);
      bit ok;
      ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (d[i*4 +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   // ---------------- driver tasks ----------------
   // One clock; inputs change 1 time unit after the rising edge, and
   // outputs read after a step reflect that edge.
   task automatic step();
      @(posedge clk);
      #1;
      if (half_a != 0) begin
         cnt_a++;
         if (cnt_a >= half_a) begin cnt_a = 0; ifa.sig_in = ~ifa.sig_in; end
      end
      if (half_b != 0) begin
         cnt_b++;
         if (cnt_b >= half_b) begin cnt_b = 0; ifb.sig_in = ~ifb.sig_in; end
      end
      if (half_c != 0) begin
         cnt_c++;
         if (cnt_c >= half_c) begin cnt_c = 0; ifc.sig_in = ~ifc.sig_in; end
      end
   endtask

   task automatic set_sig(input int which, input logic v);
      case (which)
         0:       ifa.sig_in = v;
         1:       ifb.sig_in = v;
         default: ifc.sig_in = v;
      endcase
   endtask

   // n rising edges at period 2
   task automatic pulse_edges(input int which, input int n);
      for (int i = 0; i < n; i++) begin
         set_sig(which, 1'b1);
         step();
         set_sig(which, 1'b0);
         step();
      end
   endtask

   // Steps until the chosen instance raises done; an expired budget is a failure
   task automatic wait_done(input int which, input int budget, output int cycles);
      bit seen;
      seen   = 1'b0;
      cycles = 0;
      while (!seen && cycles < budget) begin
         step();
         cycles++;
         case (which)
            0:       seen = ifa.done;
            1:       seen = ifb.done;
            default: seen = ifc.done;
         endcase
      end
      if (!seen) begin
         n_checks++;
         $display("FAIL wait_done dut%0d: no done within %0d cycles", which, budget);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int  k;
      bit  seen;
      half_a = 2; cnt_a = 0;
      repeat (150) step();
      half_a = 0;
      ifa.sig_in = 1'b1;
      rst = 1'b1;
      step();
      n_checks++;
      if (ifa.gate_count !== 32'd0) $display("FAIL reset_gate: got %0d expected 0", ifa.gate_count);
      else n_pass++;
      n_checks++;
      if (dig_a !== 32'h0) $display("FAIL reset_data: got %h expected 00000000", dig_a);
      else n_pass++;
      n_checks++;
      if (ifa.overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", ifa.overflow);
      else n_pass++;
      n_checks++;
      if (ifa.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", ifa.done);
      else n_pass++;
      step();
      step();
      rst = 1'b0;
      n_checks++;
      if (ifa.gate_count !== 32'd0) $display("FAIL reset_gate_held: got %0d expected 0", ifa.gate_count);
      else n_pass++;
      k = 0; seen = 1'b0;
      while (!seen && k < 250) begin
         step();
         k++;
         seen = ifa.done;
      end
      n_checks++;
      if (k !== 100 || !seen) $display("FAIL reset_first_done: got %0d cycles expected 100", k);
      else n_pass++;
      // sig_in held high across reset release is one edge
      n_checks++;
      if (dig_a !== 32'h1) $display("FAIL reset_held_high_edge: got %h expected 00000001", dig_a);
      else n_pass++;
      n_checks++;
      if (ifa.overflow !== 1'b0) $display("FAIL reset_first_overflow: got %b expected 0", ifa.overflow);
      else n_pass++;
   endtask

   task automatic test_steady();
      int cyc;
      half_a = 2; cnt_a = 0;
      repeat (30) step();
      wait_done(0, 250, cyc);
      wait_done(0, 250, cyc);
      n_checks++;
      if (cyc !== 100) $display("FAIL steady_period1: got %0d expected 100", cyc);
      else n_pass++;
      n_checks++;
      if (dig_a !== 32'h25) $display("FAIL steady_count1: got %h expected 00000025", dig_a);
      else n_pass++;
      n_checks++;
      if (ifa.overflow !== 1'b0) $display("FAIL steady_overflow: got %b expected 0", ifa.overflow);
      else n_pass++;
      step();
      n_checks++;
      if (ifa.done !== 1'b0) $display("FAIL steady_done_width: got %b expected 0", ifa.done);
      else n_pass++;
      n_checks++;
      if (dig_a !== 32'h25) $display("FAIL steady_hold: got %h expected 00000025", dig_a);
      else n_pass++;
      wait_done(0, 250, cyc);
      n_checks++;
      if (cyc !== 99) $display("FAIL steady_period2: got %0d expected 99", cyc);
      else n_pass++;
      n_checks++;
      if (dig_a !== 32'h25) $display("FAIL steady_count2: got %h expected 00000025", dig_a);
      else n_pass++;
   endtask

   task automatic test_boundary_edge();
      int cyc;
      int k;
      half_a = 0;
      ifa.sig_in = 1'b0;
      repeat (5) step();
      wait_done(0, 250, cyc);
      k = 0;
      while (ifa.gate_count !== 32'd97 && k < 250) begin step(); k++; end
      n_checks++;
      if (ifa.gate_count !== 32'd97) $display("FAIL boundary_reach97: got %0d expected 97", ifa.gate_count);
      else n_pass++;
      // edge high while gate_count == 99 -> ending window
      ifa.sig_in = 1'b1;
      step();
      step();
      step();
      n_checks++;
      if (ifa.done !== 1'b1) $display("FAIL boundary_done_a: got %b expected 1", ifa.done);
      else n_pass++;
      n_checks++;
      if (dig_a !== 32'h1) $display("FAIL boundary_in_window: got %h expected 00000001", dig_a);
      else n_pass++;
      ifa.sig_in = 1'b0;
      k = 0;
      while (ifa.gate_count !== 32'd98 && k < 250) begin step(); k++; end
      n_checks++;
      if (ifa.gate_count !== 32'd98) $display("FAIL boundary_reach98: got %0d expected 98", ifa.gate_count);
      else n_pass++;
      // edge high while gate_count == 100 -> next window
      ifa.sig_in = 1'b1;
      step();
      step();
      n_checks++;
      if (ifa.done !== 1'b1) $display("FAIL boundary_done_b: got %b expected 1", ifa.done);
      else n_pass++;
      n_checks++;
      if (dig_a !== 32'h0) $display("FAIL boundary_late_excluded: got %h expected 00000000", dig_a);
      else n_pass++;
      step();
      ifa.sig_in = 1'b0;
      wait_done(0, 250, cyc);
      n_checks++;
      if (dig_a !== 32'h1) $display("FAIL boundary_late_next: got %h expected 00000001", dig_a);
      else n_pass++;
   endtask

   task automatic test_bcd_carry();
      int cyc;
      int pat[3] = '{199, 909, 10};
      half_b = 1; cnt_b = 0;
      wait_done(1, 4500, cyc);
      wait_done(1, 4500, cyc);
      n_checks++;
      if (dig_b !== 32'h1000) $display("FAIL bcd_full_rate: got %h expected 00001000", dig_b);
      else n_pass++;
      n_checks++;
      if (ifb.overflow !== 1'b0) $display("FAIL bcd_overflow: got %b expected 0", ifb.overflow);
      else n_pass++;
      half_b = 0;
      ifb.sig_in = 1'b0;
      wait_done(1, 4500, cyc);
      for (int p = 0; p < 3; p++) begin
         pulse_edges(1, pat[p]);
         wait_done(1, 4500, cyc);
         n_checks++;
         if (dig_b !== to_bcd(pat[p]))
            $display("FAIL bcd_count_%0d: got %h expected %h", pat[p], dig_b, to_bcd(pat[p]));
         else n_pass++;
         n_checks++;
         if (!is_bcd(dig_b)) $display("FAIL bcd_digits_valid: got %h expected all nibbles <= 9", dig_b);
         else n_pass++;
      end
   endtask

   task automatic test_saturation();
      int cyc;
      half_c = 1; cnt_c = 0;
      wait_done(2, 700, cyc);
      wait_done(2, 700, cyc);
      n_checks++;
      if (dig_c !== 32'h99) $display("FAIL sat_data: got %h expected 00000099", dig_c);
      else n_pass++;
      n_checks++;
      if (ifc.overflow !== 1'b1) $display("FAIL sat_overflow: got %b expected 1", ifc.overflow);
      else n_pass++;
      half_c = 0;
      ifc.sig_in = 1'b0;
      wait_done(2, 700, cyc);
      wait_done(2, 700, cyc);
      n_checks++;
      if (dig_c !== 32'h0) $display("FAIL sat_clear_data: got %h expected 00000000", dig_c);
      else n_pass++;
      n_checks++;
      if (ifc.overflow !== 1'b0) $display("FAIL sat_clear_overflow: got %b expected 0", ifc.overflow);
      else n_pass++;
      pulse_edges(2, 99);
      wait_done(2, 700, cyc);
      n_checks++;
      if (dig_c !== 32'h99 || ifc.overflow !== 1'b0)
         $display("FAIL sat_exact_99: got %h ovf %b expected 00000099 ovf 0", dig_c, ifc.overflow);
      else n_pass++;
      pulse_edges(2, 100);
      wait_done(2, 700, cyc);
      n_checks++;
      if (dig_c !== 32'h99 || ifc.overflow !== 1'b1)
         $display("FAIL sat_exact_100: got %h ovf %b expected 00000099 ovf 1", dig_c, ifc.overflow);
      else n_pass++;
   endtask

   task automatic test_mid_window_reset();
      int  cyc;
      int  k;
      bit  seen;
      bit  stale;
      pulse_edges(1, 60);
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++;
      if (ifb.gate_count !== 32'd0 || dig_b !== 32'h0 || ifb.done !== 1'b0)
         $display("FAIL midreset_state: got gate %0d data %h done %b expected 0 0 0",
                  ifb.gate_count, dig_b, ifb.done);
      else n_pass++;
      k = 0; seen = 1'b0; stale = 1'b0;
      while (!seen && k < 2500) begin
         ifb.sig_in = (k < 14) && (k % 2 == 0);
         step();
         k++;
         seen = ifb.done;
         if (!seen && (dig_b !== 32'h0 || ifb.overflow !== 1'b0)) stale = 1'b1;
      end
      n_checks++;
      if (stale !== 1'b0) $display("FAIL midreset_stale: got %b expected 0", stale);
      else n_pass++;
      n_checks++;
      if (k !== 2000 || !seen) $display("FAIL midreset_first_done: got %0d cycles expected 2000", k);
      else n_pass++;
      n_checks++;
      if (dig_b !== 32'h7) $display("FAIL midreset_count: got %h expected 00000007", dig_b);
      else n_pass++;
      wait_done(1, 4500, cyc);
      n_checks++;
      if (cyc !== 2000) $display("FAIL midreset_period: got %0d expected 2000", cyc);
      else n_pass++;
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      rst        = 1'b1;
      ifa.sig_in = 1'b0;
      ifb.sig_in = 1'b0;
      ifc.sig_in = 1'b0;
      repeat (3) step();
      rst = 1'b0;

      test_reset();
      test_steady();
      test_boundary_edge();
      test_bcd_carry();
      test_saturation();
      test_mid_window_reset();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
